// File: rtl/pcss_link_pkg.sv
// pcss_link_pkg: definitions shared by the inter-chip link receiver and the
// future link transmitter.
//   - CHIPDATA_WIDTH_DEF / PKT_W_DEF : default beat and packet widths
//   - link_state_e                   : receiver handshake FSM states
//   - link_parity()                  : even-parity helper over a beat
package pcss_link_pkg;

    localparam int CHIPDATA_WIDTH_DEF = 16;
    localparam int PKT_W_DEF          = 64;

    // Widest beat the parity helper accepts. Narrower beats are zero-extended
    // by the caller, and zero-extension does not change the parity.
    localparam int LINK_MAX_W = 64;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_ACK  = 1'b1
    } link_state_e;

    // Even parity of a beat: the bit the sender puts on the parity wire.
    function automatic logic link_parity(input logic [LINK_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/chip_link_sync2.sv
// chip_link_sync2: two-flop synchronizer for a single level signal crossing
// into the clk domain. Both flops reset to 0.
//   clk   in   destination clock
//   rst_n in   asynchronous active-low reset
//   d     in   asynchronous level input
//   q     out  synchronized level, two clk edges after d
module chip_link_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/chip_link_rx.sv
// chip_link_rx: inter-chip link receiver. It accepts CHIPDATA_WIDTH-bit beats
// over a four-phase handshake with even parity, assembles them MSB-first into
// one PKT_W-bit packet and offers the packet to the router over valid/ready.
// Packets that contain a parity-failed beat are dropped and counted.
//
// Optional feature macro: CHIP_LINK_RX_SYNC_EN. When defined, recv_data_valid
// goes through a 2-flop synchronizer. recv_data_in and recv_data_par are
// sampled directly because the sender holds them stable while valid is high.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   recv_data_in     link beat
//   recv_data_valid  sender request (four-phase)
//   recv_data_par    even parity of recv_data_in
//   recv_data_ready  acknowledge (registered)
//   recv_data_err    parity fail for the beat being acknowledged (registered)
//   pkt_out          assembled packet, beat 0 in the top CHIPDATA_WIDTH bits
//   pkt_valid        packet available
//   pkt_ready        router accepts packet
//   err_cnt          saturating count of dropped packets
//   fsm_state        current handshake FSM state (observability)
//
// Handshake rules:
//   Link side (four-phase): the sender raises valid with data and parity held
//   stable. The receiver raises ready. The sender drops valid, and the
//   receiver then drops ready. A beat is consumed on the S_WAIT->S_ACK edge.
//   Router side (valid/ready): a packet transfers on every clock edge where
//   pkt_valid && pkt_ready. pkt_out is held stable while pkt_valid && !pkt_ready.
//
// PKT_W must be an integer multiple of CHIPDATA_WIDTH.
module chip_link_rx
    import pcss_link_pkg::*;
#(
    parameter int CHIPDATA_WIDTH = CHIPDATA_WIDTH_DEF,
    parameter int PKT_W          = PKT_W_DEF,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHIPDATA_WIDTH-1:0] recv_data_in,
    input  logic                      recv_data_valid,
    input  logic                      recv_data_par,
    output logic                      recv_data_ready,
    output logic                      recv_data_err,
    output logic [PKT_W-1:0]          pkt_out,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    output link_state_e               fsm_state
);

    localparam int BEATS = PKT_W / CHIPDATA_WIDTH;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    logic vld_i;

`ifdef CHIP_LINK_RX_SYNC_EN
    chip_link_sync2 u_sync_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (recv_data_valid),
        .q     (vld_i)
    );
`else
    assign vld_i = recv_data_valid;
`endif

    link_state_e     state_q, state_d;
    logic [BCW-1:0]  beat_q, beat_d;
    logic [PKT_W-1:0] asm_q, asm_d;
    logic            bad_q, bad_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic            is_last;
    logic            out_blocked;
    logic            par_fail;
    logic [PKT_W-1:0] asm_shift;
    logic            load_pkt;
    logic            drop_pkt;

    assign is_last   = (beat_q == LAST_BEAT);
    // The output register only blocks the last beat. It does not block when
    // the router drains the held packet on the same edge.
    assign out_blocked = is_last && pkt_valid && !pkt_ready;
    assign par_fail  = link_parity(LINK_MAX_W'(recv_data_in)) ^ recv_data_par;
    assign asm_shift = (asm_q << CHIPDATA_WIDTH) | PKT_W'(recv_data_in);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        asm_d    = asm_q;
        bad_d    = bad_q;
        ready_d  = ready_q;
        err_d    = err_q;
        load_pkt = 1'b0;
        drop_pkt = 1'b0;

        case (state_q)
            S_WAIT: begin
                ready_d = 1'b0;
                err_d   = 1'b0;
                if (vld_i && !out_blocked) begin
                    state_d = S_ACK;
                    ready_d = 1'b1;
                    err_d   = par_fail;
                    asm_d   = asm_shift;
                    if (is_last) begin
                        // The packet is complete. Deliver it or drop it,
                        // and start the next packet with a clean flag.
                        bad_d = 1'b0;
                        if (bad_q || par_fail) begin
                            drop_pkt = 1'b1;
                        end else begin
                            load_pkt = 1'b1;
                        end
                    end else begin
                        bad_d = bad_q | par_fail;
                    end
                end
            end
            S_ACK: begin
                if (!vld_i) begin
                    state_d = S_WAIT;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    beat_d  = is_last ? '0 : beat_q + 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT;
                ready_d = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            beat_q  <= '0;
            asm_q   <= '0;
            bad_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            bad_q   <= bad_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // One-entry output register. A load on the same edge as a drain replaces
    // the packet, so pkt_valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_out   <= '0;
            pkt_valid <= 1'b0;
        end else begin
            if (load_pkt) begin
                pkt_out   <= asm_shift;
                pkt_valid <= 1'b1;
            end else if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (drop_pkt && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign recv_data_ready = ready_q;
    assign recv_data_err   = err_q;
    assign fsm_state       = state_q;

endmodule

// File: tb/tb_chip_link_rx.sv
// tb_chip_link_rx: directed testbench for chip_link_rx (ERR_CNT_W=2 so that
// err_cnt saturation is reachable). Handshake latency expectations follow
// CHIP_LINK_RX_SYNC_EN: 3 clk with the synchronizer, 1 clk without it.
module tb_chip_link_rx;
    import pcss_link_pkg::*;

    localparam int CW = 16;
    localparam int PW = 64;
    localparam int EW = 2;
`ifdef CHIP_LINK_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int BUDGET = 40;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] recv_data_in = '0;
    logic          recv_data_valid = 1'b0;
    logic          recv_data_par = 1'b0;
    logic          recv_data_ready;
    logic          recv_data_err;
    logic [PW-1:0] pkt_out;
    logic          pkt_valid;
    logic          pkt_ready = 1'b0;
    logic [EW-1:0] err_cnt;
    link_state_e   fsm_state;

    always #5 clk = ~clk;

    chip_link_rx #(
        .CHIPDATA_WIDTH (CW),
        .PKT_W          (PW),
        .ERR_CNT_W      (EW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .recv_data_in    (recv_data_in),
        .recv_data_valid (recv_data_valid),
        .recv_data_par   (recv_data_par),
        .recv_data_ready (recv_data_ready),
        .recv_data_err   (recv_data_err),
        .pkt_out         (pkt_out),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .err_cnt         (err_cnt),
        .fsm_state       (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_err = 0;
    int            n_acc = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_pkt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [CW-1:0] d, input bit flip);
        recv_data_in    = d;
        recv_data_par   = (^d) ^ flip;
        recv_data_valid = 1'b1;
    endtask

    task automatic wait_ready(input logic level, input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((recv_data_ready !== level) && (n < BUDGET));
        check(tag, recv_data_ready, level);
    endtask

    task automatic send_beat(input logic [CW-1:0] d, input bit flip);
        int n;
        drive_beat(d, flip);
        wait_ready(1'b1, "ack_rise", n);
        check("ack_rise_latency", n, LAT);
        check("beat_err", recv_data_err, flip);
        recv_data_valid = 1'b0;
        wait_ready(1'b0, "ack_fall", n);
        check("ack_fall_latency", n, LAT);
        check("err_clear", recv_data_err, 1'b0);
    endtask

    // flip_beat < 0 sends a clean packet.
    task automatic send_pkt(input logic [PW-1:0] p, input int flip_beat, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            send_beat(p[PW-1-CW*b -: CW], b == flip_beat);
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (rst_n && pkt_valid && pkt_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $error("FAIL unexpected_pkt: observed=%h expected=none", pkt_out);
            end else begin
                exp_pkt = exp_q.pop_front();
                check("pkt_out", pkt_out, exp_pkt);
            end
        end
    end

    // Time limit so that a stuck design still ends the run.
    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    localparam logic [PW-1:0] PKT_G = 64'h0123_4567_89AB_CDEF;
    localparam logic [PW-1:0] PKT_H = 64'hFEDC_BA98_7654_3210;
    localparam logic [PW-1:0] PKT_A = 64'h1111_2222_3333_4444;
    localparam logic [PW-1:0] PKT_B = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [PW-1:0] PKT_C = 64'hC0DE_0001_C0DE_0002;
    localparam logic [PW-1:0] PKT_D = 64'hD00D_BEEF_CAFE_F00D;
    localparam logic [PW-1:0] PKT_E = 64'h8000_0001_7FFF_FFFE;
    localparam logic [PW-1:0] PKT_X = 64'hDEAD_BEEF_0BAD_F00D;

    initial begin
        logic [EW-1:0] sat_exp [5];
        int n;
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset state
        repeat (3) tick();
        check("rst_ready", recv_data_ready, 1'b0);
        check("rst_err", recv_data_err, 1'b0);
        check("rst_pkt_valid", pkt_valid, 1'b0);
        check("rst_pkt_out", pkt_out, 64'h0);
        check("rst_err_cnt", err_cnt, 2'd0);
        check("rst_state", fsm_state, S_WAIT);
        rst_n = 1'b1;
        tick();

        // Good packet
        pkt_ready = 1'b1;
        exp_q.push_back(PKT_G);
        send_pkt(PKT_G, -1, 4);
        repeat (2) tick();
        check("good_err_cnt", err_cnt, 2'd0);
        check("good_accepted", n_acc, 1);

        // Parity fail on beat 2: dropped. The next packet is intact.
        send_pkt(PKT_G, 2, 4);
        repeat (2) tick();
        check("par_err_cnt", err_cnt, 2'd1);
        check("par_no_pkt", n_acc, 1);
        exp_q.push_back(PKT_H);
        send_pkt(PKT_H, -1, 4);
        repeat (2) tick();
        check("after_par_accepted", n_acc, 2);

        // Backpressure: A is held. B's last beat waits for the router.
        pkt_ready = 1'b0;
        exp_q.push_back(PKT_A);
        send_pkt(PKT_A, -1, 4);
        check("bp_a_valid", pkt_valid, 1'b1);
        check("bp_a_out", pkt_out, PKT_A);
        exp_q.push_back(PKT_B);
        send_pkt(PKT_B, -1, 3);
        drive_beat(PKT_B[CW-1:0], 1'b0);
        repeat (10) tick();
        check("bp_ready_withheld", recv_data_ready, 1'b0);
        check("bp_a_stable", pkt_out, PKT_A);
        check("bp_a_still_valid", pkt_valid, 1'b1);
        pkt_ready = 1'b1;
        wait_ready(1'b1, "bp_ack", n);
        check("bp_ack_latency", n, 1);
        check("bp_b_out", pkt_out, PKT_B);
        check("bp_b_valid", pkt_valid, 1'b1);
        recv_data_valid = 1'b0;
        wait_ready(1'b0, "bp_release", n);
        check("bp_b_drained", pkt_valid, 1'b0);
        check("bp_accepted", n_acc, 4);

        // Drain and load on the same edge
        pkt_ready = 1'b0;
        exp_q.push_back(PKT_C);
        send_pkt(PKT_C, -1, 4);
        exp_q.push_back(PKT_D);
        send_pkt(PKT_D, -1, 3);
        drive_beat(PKT_D[CW-1:0], 1'b0);
        repeat (LAT - 1) tick();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        check("sim_ack", recv_data_ready, 1'b1);
        check("sim_valid_kept", pkt_valid, 1'b1);
        check("sim_out_new", pkt_out, PKT_D);
        check("sim_c_accepted", n_acc, 5);
        recv_data_valid = 1'b0;
        wait_ready(1'b0, "sim_release", n);
        check("sim_d_held", pkt_out, PKT_D);
        pkt_ready = 1'b1;
        repeat (2) tick();
        check("sim_d_drained", pkt_valid, 1'b0);
        check("sim_accepted", n_acc, 6);

        // Reset mid-packet (err_cnt is 1 here and must clear)
        send_pkt(PKT_X, -1, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", recv_data_ready, 1'b0);
        check("mid_rst_err", recv_data_err, 1'b0);
        check("mid_rst_pkt_valid", pkt_valid, 1'b0);
        check("mid_rst_pkt_out", pkt_out, 64'h0);
        check("mid_rst_err_cnt", err_cnt, 2'd0);
        check("mid_rst_state", fsm_state, S_WAIT);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back(PKT_E);
        send_pkt(PKT_E, -1, 4);
        repeat (2) tick();
        check("post_rst_accepted", n_acc, 7);

        // err_cnt saturates at 3
        for (int i = 0; i < 5; i++) begin
            send_pkt(PKT_X ^ PW'(i), 0, 4);
            tick();
            check("sat_err_cnt", err_cnt, sat_exp[i]);
        end

        repeat (4) tick();
        check("queue_empty", exp_q.size(), 0);
        check("total_accepted", n_acc, 7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/chip_link_rx.md
# chip_link_rx

Inter-chip link receiver that sits directly behind each `recv_data_*` port of `pcss_top`. It accepts 16-bit beats from the neighbouring chip over a four-phase valid/ready handshake with even parity. It reassembles the beats MSB-first into one PKT_W-bit packet and presents it to the on-chip router on a standard valid/ready interface. Packets containing a parity-failed beat are dropped and counted.

## Interface
Parameters:
- CHIPDATA_WIDTH, 16: width of one link beat.
- PKT_W, 64: packet width (FW+CONNECT_WIDTH). Must be an integer multiple of CHIPDATA_WIDTH.
- ERR_CNT_W, 8: width of the parity-error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- recv_data_in  in  CHIPDATA_WIDTH  link beat. Held stable by the sender while recv_data_valid is high.
- recv_data_valid  in  1  sender request (four-phase).
- recv_data_par  in  1  even parity of recv_data_in (`^recv_data_in`).
- recv_data_ready  out  1  acknowledge, registered.
- recv_data_err  out  1  parity-fail flag for the current beat, registered.
- pkt_out  out  PKT_W  assembled packet. Beat 0 occupies bits [PKT_W-1:PKT_W-CHIPDATA_WIDTH].
- pkt_valid  out  1  packet available.
- pkt_ready  in  1  router accepts packet.
- err_cnt  out  ERR_CNT_W  saturating count of dropped packets.

## Operation
- Local parameter BEATS = PKT_W/CHIPDATA_WIDTH (4 by default). beat_cnt is log2(BEATS) bits wide.
- vld_i is recv_data_valid, passed through the synchronizer when one is configured.

FSM:
- S_WAIT: ready=0, err=0.
  - On vld_i=1, go to S_ACK, unless this is the last beat (beat_cnt==BEATS-1) and the output register is full without being drained this cycle (pkt_valid && !pkt_ready). In that case, stall in S_WAIT.
  - On the transition, shift recv_data_in into the assembly register. Evaluate parity as `^{recv_data_in, recv_data_par}`: nonzero means a parity fail, which sets the bad flag and drives err=1 together with ready=1.
- S_ACK: ready=1. err holds its value from the transition into S_ACK.
  - On vld_i=0, go to S_WAIT with ready=0 and err=0, and increment beat_cnt.
- Last beat:
  - Good packet (bad flag clear): on the S_WAIT→S_ACK edge of the last beat, load pkt_out and set pkt_valid. beat_cnt wraps to 0 on exit from S_ACK.
  - Bad packet (bad flag set): do not load pkt_out or set pkt_valid. Increment err_cnt, saturating at all-ones with no wrap. Clear the bad flag.
- Output register:
  - Holds one packet.
  - pkt_valid clears on pkt_valid && pkt_ready, unless a new packet loads in the same cycle. In that case pkt_valid stays 1 and pkt_out takes the new value.
  - pkt_out is stable while pkt_valid && !pkt_ready.
- Backpressure reaches the link only by withholding the last-beat ready. Beats 0..BEATS-2 are always acknowledged.

## Timing
- Reset values: recv_data_ready=0, recv_data_err=0, pkt_valid=0, pkt_out=0, err_cnt=0. beat_cnt=0, the bad flag clears, and the FSM enters S_WAIT.
- Reset mid-packet discards the partial packet. The first beat after reset is beat 0.
- Handshake latency, without sync: ready rises 1 clk after valid is sampled high, and falls 1 clk after valid is sampled low.
- Handshake latency, with sync: each edge takes 3 clk (2 sync stages plus the registered output).
- pkt_valid rises on the same edge as ready for the last beat.
- Throughput ceiling: one beat per 4 clk without sync, one beat per 8 clk with sync.
- Valid dropping before ready rises is a sender protocol violation. The FSM stays in S_WAIT and nothing is captured.

## Configuration
- Macro: CHIP_LINK_RX_SYNC_EN.
- Defined: recv_data_valid passes through a 2-flop synchronizer reset to 0. recv_data_in and recv_data_par are sampled unsynchronized, because they are stable while valid is high.
- Undefined: recv_data_valid feeds the FSM directly, for same-clock chip-to-chip or simulation use.

## Structure
- Shared package pcss_link_pkg holds:
  - CHIPDATA_WIDTH and PKT_W defaults.
  - FSM state typedef {S_WAIT, S_ACK}.
  - A parity helper function, shared with the future link transmitter.
- One sub-module, chip_link_sync2: the 2-flop synchronizer, instantiated only under CHIP_LINK_RX_SYNC_EN.

## Test plan
- Good packet: send 0x0123_4567_89AB_CDEF as four beats 0x0123, 0x4567, 0x89AB, 0xCDEF, with pkt_ready=1. Expect one pkt_valid pulse with pkt_out=0x0123456789ABCDEF and err_cnt=0.
- Parity fail: send the same packet with the beat-2 parity inverted. Expect recv_data_err=1 only during beat 2's ack, no pkt_valid, and err_cnt=1. The next good packet must be delivered intact.
- Backpressure: pkt_ready=0 while two packets are sent. Expect the first packet held stable and the second packet's beat-3 ready withheld. Raise pkt_ready: beat 3 is acked and the second packet appears the cycle after the first is accepted.
- Simultaneous drain and load: pkt_ready pulses on the same cycle the last beat is acked. Expect pkt_valid to stay 1 and pkt_out to update with no lost packet.
- Reset mid-packet: assert rst_n=0 after beat 1. Expect all outputs at reset values. A fresh 4-beat packet then decodes correctly.
- err_cnt saturation with ERR_CNT_W=2: send 5 bad packets. Expect err_cnt to stop at 3. Run with and without CHIP_LINK_RX_SYNC_EN and confirm 3-clk versus 1-clk ready latency.
